sa_os_tile_scheduler: RTL and testbench
=======================================

Name: sa_os_tile_scheduler

Overview:
Sequencing controller for the output-stationary systolic array in the AXIS_SA_OS datapath. It walks the M×L result matrix in P×Q output tiles, row-major with tile column innermost. For each tile it clears the accumulators, streams the N reduction steps, waits out the array skew, then requests a result drain. It exports tile origin and valid-extent information so the feeders can zero-pad edge tiles and the output stage can generate tlast.

Parameters:
M, 25, rows of A and C
N, 19, shared reduction dimension (cols of A, rows of B)
L, 17, cols of B and C
P, 8, PE array rows (tile height)
Q, 8, PE array cols (tile width)
SKEW, P+Q-1, flush cycles after the last feed beat before drain is legal

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin one full matrix job; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE completes
done  out  1  one-cycle pulse at job end
acc_clr  out  1  one-cycle pulse, clear all PE accumulators
feed_valid  out  1  feed beat k is being offered to the A/B skew feeders
feed_ready  in  1  feeders accept the beat
feed_k  out  $clog2(N)  reduction index of the current beat
feed_last  out  1  feed_valid and feed_k==N-1
tile_row0  out  $clog2(M)  first C row of the current tile (tr*P)
tile_col0  out  $clog2(L)  first C col of the current tile (tc*Q)
rows_vld  out  $clog2(P+1)  valid rows in tile: min(P, M-tile_row0)
cols_vld  out  $clog2(Q+1)  valid cols in tile: min(Q, L-tile_col0)
drain_req  out  1  request the output stage to drain the tile
drain_ack  in  1  output stage finished the drain
last_tile  out  1  current tile is the final tile of the job
tile_cnt  out  $clog2(TR*TC+1)  tiles completed in the current job

Behaviour:
- Derived constants: TR=ceil(M/P), TC=ceil(L/Q).
- Reset (async, rst_n low): state IDLE; all outputs 0; tr, tc, k, flush counter and tile_cnt cleared. Takes effect immediately, including mid-job. No drain_req is left pending.
- FSM states: IDLE, CLR, FEED, FLUSH, DRAIN, DONE.
- IDLE:
  - start=1 → CLR, tr=tc=0, tile_cnt=0, busy=1.
  - start in any other state is ignored.
- CLR:
  - acc_clr=1 for exactly one cycle, k=0 → FEED.
- FEED:
  - feed_valid=1; feed_k holds while feed_ready=0.
  - On valid&&ready: if k==N-1 → FLUSH with flush count 0, else k+1.
  - A tile consumes exactly N handshakes.
- FLUSH:
  - feed_valid=0; counts SKEW cycles, then → DRAIN.
- DRAIN:
  - drain_req=1, held until drain_ack is sampled high. drain_ack may be high in the first DRAIN cycle, giving a one-cycle DRAIN.
  - On ack: tile_cnt+1.
  - If last_tile → DONE. Otherwise advance: tc+1; on tc==TC-1, tc=0 and tr+1. Then → CLR.
  - drain_ack outside DRAIN is ignored.
- DONE:
  - done=1 for one cycle, busy=0 → IDLE.
  - A start in the DONE cycle is ignored; a start in the following IDLE cycle is accepted.
- Tile info: tile_row0, tile_col0, rows_vld, cols_vld and last_tile are registered. They are stable from CLR through DRAIN of the tile and update together on tile advance.
  - last_tile = (tr==TR-1)&&(tc==TC-1).
- Tile arithmetic: multiplications by P and Q are constants and unsigned. rows_vld and cols_vld are never 0.
- Cycle budget, feed_ready=1 and drain_ack=1 combinational: per tile 1 (CLR) + N (FEED) + SKEW (FLUSH) + 1 (DRAIN). done is asserted TR*TC*(N+SKEW+2)+1 cycles after the start sample edge.

Test Plan:
- Defaults, feed_ready=1, drain_ack tied to drain_req:
  - 12 tiles, 228 feed handshakes, 12 acc_clr and 12 drain_req pulses.
  - Tile order (row0,col0) = (0,0),(0,8),(0,16),(8,0)…(24,16).
  - done at cycle 433; tile_cnt=12.
- Edge extents: tile (0,16) gives rows_vld=8, cols_vld=1; tile (24,0) gives rows_vld=1, cols_vld=8; tile (24,16) gives rows_vld=1, cols_vld=1, last_tile=1.
- Random feed_ready (≈50%) and drain_ack delayed 0–20 cycles:
  - feed_k never skips and holds under stall.
  - Exactly N beats per tile; feed_last only on k=18.
  - drain_req held until ack; done still follows the 12th ack by one cycle.
- start pulsed repeatedly during FEED and DRAIN → ignored, no restart. A second start after done → a second identical 12-tile job.
- rst_n asserted mid-FEED of tile 5 → all outputs 0 immediately. Restart with start → tile order again begins at (0,0); tile_cnt restarts from 0.
- Parameter corner M=P=N=L=Q=8, SKEW=15 → single tile, last_tile=1 from CLR, rows_vld=cols_vld=8, done 26 cycles after the start sample edge.

Source files
------------

// File: rtl/sa_os_tile_scheduler_if.sv
// Job/feed/drain bundle between the tile scheduler and its neighbours.
// master: scheduler (drives status, feed, tile info, drain_req); slave: host/feeders/output stage.
interface sa_os_tile_scheduler_if #(
  parameter int M = 25,
  parameter int N = 19,
  parameter int L = 17,
  parameter int P = 8,
  parameter int Q = 8
);
  localparam int TR  = (M + P - 1) / P;
  localparam int TC  = (L + Q - 1) / Q;
  localparam int KW  = (N > 1) ? $clog2(N) : 1;
  localparam int RW  = (M > 1) ? $clog2(M) : 1;
  localparam int CW  = (L > 1) ? $clog2(L) : 1;
  localparam int RVW = $clog2(P + 1);
  localparam int CVW = $clog2(Q + 1);
  localparam int TW  = $clog2(TR * TC + 1);

  logic           start;
  logic           busy;
  logic           done;
  logic           acc_clr;
  logic           feed_valid;
  logic           feed_ready;
  logic [KW-1:0]  feed_k;
  logic           feed_last;
  logic [RW-1:0]  tile_row0;
  logic [CW-1:0]  tile_col0;
  logic [RVW-1:0] rows_vld;
  logic [CVW-1:0] cols_vld;
  logic           drain_req;
  logic           drain_ack;
  logic           last_tile;
  logic [TW-1:0]  tile_cnt;

  modport master (
    input  start, feed_ready, drain_ack,
    output busy, done, acc_clr, feed_valid, feed_k, feed_last,
    output tile_row0, tile_col0, rows_vld, cols_vld,
    output drain_req, last_tile, tile_cnt
  );

  modport slave (
    output start, feed_ready, drain_ack,
    input  busy, done, acc_clr, feed_valid, feed_k, feed_last,
    input  tile_row0, tile_col0, rows_vld, cols_vld,
    input  drain_req, last_tile, tile_cnt
  );
endinterface

// File: rtl/sa_os_tile_scheduler.sv
// Output-stationary systolic array tile sequencer: clear, feed N beats, flush, drain per tile.
// Ports: clk, rst_n (async active-low), bus (master side of sa_os_tile_scheduler_if).
module sa_os_tile_scheduler #(
  parameter int M    = 25,
  parameter int N    = 19,
  parameter int L    = 17,
  parameter int P    = 8,
  parameter int Q    = 8,
  parameter int SKEW = P + Q - 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sa_os_tile_scheduler_if.master bus
);
  localparam int TR  = (M + P - 1) / P;
  localparam int TC  = (L + Q - 1) / Q;
  localparam int KW  = (N > 1) ? $clog2(N) : 1;
  localparam int RW  = (M > 1) ? $clog2(M) : 1;
  localparam int CW  = (L > 1) ? $clog2(L) : 1;
  localparam int RVW = $clog2(P + 1);
  localparam int CVW = $clog2(Q + 1);
  localparam int TW  = $clog2(TR * TC + 1);
  localparam int TRW = (TR > 1) ? $clog2(TR) : 1;
  localparam int TCW = (TC > 1) ? $clog2(TC) : 1;
  localparam int FW  = (SKEW > 1) ? $clog2(SKEW) : 1;

  typedef enum logic [2:0] {
    IDLE, CLR, FEED, FLUSH, DRAIN, DONE
  } state_t;

  state_t         state;
  logic [KW-1:0]  k;
  logic [FW-1:0]  fcnt;
  logic [TRW-1:0] tr, tr_n;
  logic [TCW-1:0] tc, tc_n;
  logic           busy, done, acc_clr;
  logic           feed_valid, drain_req, last_tile;
  logic [RW-1:0]  row0;
  logic [CW-1:0]  col0;
  logic [RVW-1:0] rows;
  logic [CVW-1:0] cols;
  logic [TW-1:0]  tcnt;

  function automatic logic [RW-1:0] row0_of(input logic [TRW-1:0] t);
    return RW'(int'(t) * P);
  endfunction

  function automatic logic [CW-1:0] col0_of(input logic [TCW-1:0] t);
    return CW'(int'(t) * Q);
  endfunction

  // Edge tiles hold fewer valid rows/cols; never zero since tr < TR.
  function automatic logic [RVW-1:0] rows_of(input logic [TRW-1:0] t);
    int r;
    r = M - int'(t) * P;
    return RVW'((r < P) ? r : P);
  endfunction

  function automatic logic [CVW-1:0] cols_of(input logic [TCW-1:0] t);
    int c;
    c = L - int'(t) * Q;
    return CVW'((c < Q) ? c : Q);
  endfunction

  function automatic logic last_of(
    input logic [TRW-1:0] r,
    input logic [TCW-1:0] c
  );
    return (r == TRW'(TR - 1)) && (c == TCW'(TC - 1));
  endfunction

  // Row-major walk, tile column innermost.
  always_comb begin
    tr_n = tr;
    tc_n = tc + 1'b1;
    if (tc == TCW'(TC - 1)) begin
      tc_n = '0;
      tr_n = tr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      fcnt       <= '0;
      tr         <= '0;
      tc         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      acc_clr    <= 1'b0;
      feed_valid <= 1'b0;
      drain_req  <= 1'b0;
      last_tile  <= 1'b0;
      row0       <= '0;
      col0       <= '0;
      rows       <= '0;
      cols       <= '0;
      tcnt       <= '0;
    end else begin
      acc_clr <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= CLR;
            busy      <= 1'b1;
            acc_clr   <= 1'b1;
            tr        <= '0;
            tc        <= '0;
            tcnt      <= '0;
            row0      <= '0;
            col0      <= '0;
            rows      <= rows_of('0);
            cols      <= cols_of('0);
            last_tile <= last_of('0, '0);
          end
        end
        CLR: begin
          k          <= '0;
          feed_valid <= 1'b1;
          state      <= FEED;
        end
        FEED: begin
          if (bus.feed_ready) begin
            if (k == KW'(N - 1)) begin
              feed_valid <= 1'b0;
              fcnt       <= '0;
              state      <= FLUSH;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (fcnt == FW'(SKEW - 1)) begin
            drain_req <= 1'b1;
            state     <= DRAIN;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        DRAIN: begin
          if (bus.drain_ack) begin
            drain_req <= 1'b0;
            tcnt      <= tcnt + 1'b1;
            if (last_tile) begin
              state <= DONE;
            end else begin
              tr        <= tr_n;
              tc        <= tc_n;
              row0      <= row0_of(tr_n);
              col0      <= col0_of(tc_n);
              rows      <= rows_of(tr_n);
              cols      <= cols_of(tc_n);
              last_tile <= last_of(tr_n, tc_n);
              acc_clr   <= 1'b1;
              state     <= CLR;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.acc_clr    = acc_clr;
  assign bus.feed_valid = feed_valid;
  assign bus.feed_k     = k;
  assign bus.feed_last  = feed_valid && (k == KW'(N - 1));
  assign bus.tile_row0  = row0;
  assign bus.tile_col0  = col0;
  assign bus.rows_vld   = rows;
  assign bus.cols_vld   = cols;
  assign bus.drain_req  = drain_req;
  assign bus.last_tile  = last_tile;
  assign bus.tile_cnt   = tcnt;
endmodule

// File: tb/tb_sa_os_tile_scheduler.sv
// Testbench for sa_os_tile_scheduler: default 25x19x17 job plus an 8x8x8 corner instance.
// Randomised stalls/ack delays checked against a tile-list and cycle-budget model.
module tb_sa_os_tile_scheduler;
  localparam int M = 25, N = 19, L = 17, P = 8, Q = 8;
  localparam int SKEW = P + Q - 1;
  localparam int TR = (M + P - 1) / P;
  localparam int TC = (L + Q - 1) / Q;
  localparam int NT = TR * TC;
  localparam int EXP_DONE = NT * (N + SKEW + 2) + 1;

  typedef struct packed {
    logic [7:0] r0, c0, rv, cv, lt, cnt;
  } tile_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic feed_ready = 1'b0;
  logic ack_drv = 1'b0;
  logic tie = 1'b1;
  logic c_start = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  tile_t seen[$];
  tile_t expt[$];
  int n_clr, n_hs, n_drain, n_done, n_ack;
  int done_edge, last_ack_edge;
  int beat_err, hold_err, last_err, busy_err;

  always #5 clk = ~clk;

  sa_os_tile_scheduler_if #(.M(M), .N(N), .L(L), .P(P), .Q(Q)) b ();
  sa_os_tile_scheduler #(
    .M(M), .N(N), .L(L), .P(P), .Q(Q), .SKEW(SKEW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  sa_os_tile_scheduler_if #(.M(8), .N(8), .L(8), .P(8), .Q(8)) c ();
  sa_os_tile_scheduler #(
    .M(8), .N(8), .L(8), .P(8), .Q(8), .SKEW(15)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(c)
  );

  assign b.start      = start;
  assign b.feed_ready = feed_ready;
  assign b.drain_ack  = tie ? b.drain_req : ack_drv;
  assign c.start      = c_start;
  assign c.feed_ready = 1'b1;
  assign c.drain_ack  = c.drain_req;

  function automatic void build_model();
    tile_t t;
    expt.delete();
    for (int r = 0; r < TR; r++)
      for (int q = 0; q < TC; q++) begin
        t.r0  = 8'(r * P);
        t.c0  = 8'(q * Q);
        t.rv  = 8'((M - r * P < P) ? M - r * P : P);
        t.cv  = 8'((L - q * Q < Q) ? L - q * Q : Q);
        t.cnt = 8'(r * TC + q);
        t.lt  = 8'(r * TC + q == NT - 1);
        expt.push_back(t);
      end
  endfunction

  // Runs one job on the main instance and logs what the bench observed.
  task automatic run_job(input bit rnd, input bit spam, input int limit);
    int n, beat, dly, dcnt;
    bit prev_v, prev_r, prev_req, prev_ack, ack_now;
    logic [4:0] prev_k;
    tile_t t;
    seen.delete();
    n_clr = 0; n_hs = 0; n_drain = 0; n_done = 0; n_ack = 0;
    done_edge = -1; last_ack_edge = -1;
    beat_err = 0; hold_err = 0; last_err = 0; busy_err = 0;
    beat = 0; dly = 0; dcnt = 0;
    prev_v = 0; prev_r = 0; prev_req = 0; prev_ack = 0; prev_k = '0;
    tie = !rnd;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      start = spam && (b.feed_valid || b.drain_req) && ($urandom_range(0, 1) == 1);
      if (b.acc_clr) begin
        n_clr++;
        t.r0 = 8'(b.tile_row0);
        t.c0 = 8'(b.tile_col0);
        t.rv = 8'(b.rows_vld);
        t.cv = 8'(b.cols_vld);
        t.lt = 8'(b.last_tile);
        t.cnt = 8'(b.tile_cnt);
        seen.push_back(t);
        beat = 0;
      end
      if (prev_v && !prev_r && !(b.feed_valid && b.feed_k == prev_k)) hold_err++;
      if (prev_req && !prev_ack && !b.drain_req) hold_err++;
      if (b.drain_req && !prev_req) begin
        n_drain++;
        dly = rnd ? int'($urandom_range(0, 20)) : 0;
        dcnt = 0;
      end
      if (b.feed_last !== (b.feed_valid && int'(b.feed_k) == N - 1)) last_err++;
      if (b.done) begin
        n_done++;
        done_edge = n - 1;
      end
      if (b.busy !== (n_done == 0)) busy_err++;
      feed_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ack_drv = rnd && b.drain_req && (dcnt >= dly);
      ack_now = tie ? b.drain_req : ack_drv;
      if (b.drain_req) dcnt++;
      if (b.feed_valid && feed_ready) begin
        n_hs++;
        if (int'(b.feed_k) != beat) beat_err++;
        beat++;
      end
      if (b.drain_req && ack_now) begin
        n_ack++;
        last_ack_edge = n;
        if (beat != N) beat_err++;
      end
      prev_v = b.feed_valid;
      prev_r = feed_ready;
      prev_k = b.feed_k;
      prev_req = b.drain_req;
      prev_ack = ack_now;
      if (n_done > 0 && n >= done_edge + 6) break;
    end
    start = 1'b0;
    feed_ready = 1'b0;
    ack_drv = 1'b0;
    tie = 1'b1;
  endtask

  task automatic test_reset();
    logic [63:0] obs;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    obs = 64'({b.busy, b.done, b.acc_clr, b.feed_valid, b.feed_k, b.feed_last,
               b.tile_row0, b.tile_col0, b.rows_vld, b.cols_vld,
               b.drain_req, b.last_tile, b.tile_cnt});
    n_cmp++;
    if (obs !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_main: outputs %h, want 0", obs);
    end
    obs = 64'({c.busy, c.done, c.acc_clr, c.feed_valid, c.feed_k, c.feed_last,
               c.tile_row0, c.tile_col0, c.rows_vld, c.cols_vld,
               c.drain_req, c.last_tile, c.tile_cnt});
    n_cmp++;
    if (obs !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_corner: outputs %h, want 0", obs);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    run_job(1'b0, 1'b0, 600);
    n_cmp++;
    if (n_done != 1) begin n_bad++; $display("FAIL nom_done_cnt: %0d, want 1", n_done); end
    n_cmp++;
    if (done_edge != EXP_DONE) begin
      n_bad++; $display("FAIL nom_done_cycle: %0d, want %0d", done_edge, EXP_DONE);
    end
    n_cmp++;
    if (n_clr != NT) begin n_bad++; $display("FAIL nom_acc_clr: %0d, want %0d", n_clr, NT); end
    n_cmp++;
    if (n_drain != NT) begin n_bad++; $display("FAIL nom_drain: %0d, want %0d", n_drain, NT); end
    n_cmp++;
    if (n_hs != NT * N) begin n_bad++; $display("FAIL nom_beats: %0d, want %0d", n_hs, NT * N); end
    n_cmp++;
    if (int'(b.tile_cnt) != NT) begin
      n_bad++; $display("FAIL nom_tile_cnt: %0d, want %0d", b.tile_cnt, NT);
    end
    n_cmp++;
    if (beat_err + hold_err + last_err + busy_err != 0) begin
      n_bad++;
      $display("FAIL nom_protocol: beat %0d hold %0d last %0d busy %0d, want 0",
               beat_err, hold_err, last_err, busy_err);
    end
    n_cmp++;
    if (seen.size() != expt.size()) begin
      n_bad++; $display("FAIL nom_tiles: %0d tiles, want %0d", seen.size(), expt.size());
    end
    for (int i = 0; i < seen.size() && i < expt.size(); i++) begin
      n_cmp++;
      if (seen[i] !== expt[i]) begin
        n_bad++;
        $display("FAIL nom_tile%0d: got r0 %0d c0 %0d rv %0d cv %0d lt %0d cnt %0d, want %0d %0d %0d %0d %0d %0d",
                 i, seen[i].r0, seen[i].c0, seen[i].rv, seen[i].cv, seen[i].lt, seen[i].cnt,
                 expt[i].r0, expt[i].c0, expt[i].rv, expt[i].cv, expt[i].lt, expt[i].cnt);
      end
    end
  endtask

  task automatic test_edge_extents();
    tile_t want[3];
    int idx[3];
    idx[0] = 2; idx[1] = 9; idx[2] = 11;
    want[0] = {8'd0, 8'd16, 8'd8, 8'd1, 8'd0, 8'd2};
    want[1] = {8'd24, 8'd0, 8'd1, 8'd8, 8'd0, 8'd9};
    want[2] = {8'd24, 8'd16, 8'd1, 8'd1, 8'd1, 8'd11};
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (seen.size() <= idx[i]) begin
        n_bad++; $display("FAIL edge_tile%0d: missing, have %0d tiles", idx[i], seen.size());
      end else if (seen[idx[i]] !== want[i]) begin
        n_bad++;
        $display("FAIL edge_tile%0d: got %h, want %h", idx[i], seen[idx[i]], want[i]);
      end
    end
  endtask

  task automatic test_random_stall();
    run_job(1'b1, 1'b0, 6000);
    n_cmp++;
    if (n_done != 1) begin n_bad++; $display("FAIL rnd_done_cnt: %0d, want 1", n_done); end
    n_cmp++;
    if (n_hs != NT * N) begin n_bad++; $display("FAIL rnd_beats: %0d, want %0d", n_hs, NT * N); end
    n_cmp++;
    if (n_ack != NT) begin n_bad++; $display("FAIL rnd_acks: %0d, want %0d", n_ack, NT); end
    n_cmp++;
    if (done_edge != last_ack_edge + 1) begin
      n_bad++; $display("FAIL rnd_done_lag: done %0d, want %0d", done_edge, last_ack_edge + 1);
    end
    n_cmp++;
    if (beat_err != 0 || hold_err != 0 || last_err != 0 || busy_err != 0) begin
      n_bad++;
      $display("FAIL rnd_protocol: beat %0d hold %0d last %0d busy %0d, want 0",
               beat_err, hold_err, last_err, busy_err);
    end
    n_cmp++;
    if (seen != expt) begin
      n_bad++; $display("FAIL rnd_tiles: %0d tiles seen, order/extents differ from model", seen.size());
    end
  endtask

  task automatic test_start_ignored();
    run_job(1'b1, 1'b1, 6000);
    n_cmp++;
    if (n_done != 1 || n_clr != NT) begin
      n_bad++; $display("FAIL spam_restart: done %0d clr %0d, want 1 %0d", n_done, n_clr, NT);
    end
    n_cmp++;
    if (seen != expt) begin
      n_bad++; $display("FAIL spam_tiles: %0d tiles seen, differ from model", seen.size());
    end
    n_cmp++;
    if (b.busy !== 1'b0) begin n_bad++; $display("FAIL spam_idle: busy %b, want 0", b.busy); end
  endtask

  task automatic test_back_to_back();
    run_job(1'b0, 1'b0, 600);
    n_cmp++;
    if (done_edge != EXP_DONE) begin
      n_bad++; $display("FAIL b2b_done_cycle: %0d, want %0d", done_edge, EXP_DONE);
    end
    n_cmp++;
    if (seen != expt) begin
      n_bad++; $display("FAIL b2b_tiles: %0d tiles seen, differ from model", seen.size());
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bit hit;
    logic [63:0] obs;
    tie = 1'b1;
    feed_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    n = 0;
    while (!hit && n < 600) begin
      if (b.feed_valid && int'(b.tile_cnt) == 5 && int'(b.feed_k) == 7) hit = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL mrst_reach: tile5 feed not seen in %0d cycles", n); end
    rst_n = 1'b0;
    #1;
    obs = 64'({b.busy, b.done, b.acc_clr, b.feed_valid, b.feed_k, b.feed_last,
               b.tile_row0, b.tile_col0, b.rows_vld, b.cols_vld,
               b.drain_req, b.last_tile, b.tile_cnt});
    n_cmp++;
    if (obs !== 64'd0) begin n_bad++; $display("FAIL mrst_outputs: %h, want 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    feed_ready = 1'b0;
    run_job(1'b0, 1'b0, 600);
    n_cmp++;
    if (seen.size() == 0 || seen[0] !== expt[0]) begin
      n_bad++; $display("FAIL mrst_first_tile: %0d tiles, first differs from (0,0) cnt 0", seen.size());
    end
    n_cmp++;
    if (seen != expt || n_done != 1) begin
      n_bad++; $display("FAIL mrst_job: tiles %0d done %0d, want %0d 1", seen.size(), n_done, NT);
    end
  endtask

  task automatic test_corner();
    int n, clr, hs, done_e;
    logic [8:0] ext;
    clr = 0; hs = 0; done_e = -1; ext = '0;
    @(negedge clk);
    c_start = 1'b1;
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      c_start = 1'b0;
      if (c.acc_clr) begin
        clr++;
        ext = {c.last_tile, c.rows_vld, c.cols_vld};
      end
      if (c.feed_valid) hs++;
      if (c.done && done_e < 0) done_e = n - 1;
    end
    n_cmp++;
    if (clr != 1 || hs != 8) begin
      n_bad++; $display("FAIL corner_counts: clr %0d beats %0d, want 1 8", clr, hs);
    end
    n_cmp++;
    if (ext !== {1'b1, 4'd8, 4'd8}) begin
      n_bad++; $display("FAIL corner_extent: %h, want %h", ext, {1'b1, 4'd8, 4'd8});
    end
    n_cmp++;
    if (done_e != 26) begin n_bad++; $display("FAIL corner_done_cycle: %0d, want 26", done_e); end
    n_cmp++;
    if (int'(c.tile_cnt) != 1 || c.busy !== 1'b0) begin
      n_bad++; $display("FAIL corner_end: tile_cnt %0d busy %b, want 1 0", c.tile_cnt, c.busy);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_nominal();
    test_edge_extents();
    test_random_stall();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    test_corner();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
